// File: rtl/scan_dac_spi.sv
// -----------------------------------------------------------------------------
// scan_dac_spi
//
// Latches the scan generator's value and writes it MSB-first over a
// write-only SPI link to an external 16-bit voltage DAC (AD5541-class).
// A write is requested by an explicit update strobe, or by any change of
// scan_value while scan_enable is high. A request that arrives while a frame
// is in flight is held in a one-deep pending flag. That flag starts the next
// frame as soon as the FSM is back in IDLE.
//
// Frame sequence (H = CLK_DIV clk cycles):
//   IDLE -> SETUP (H) -> SHIFT (2*H per bit) -> HOLD (H) -> GAP (CS_GAP*H)
//        [-> LDAC (H)] -> IDLE
//
// Optional feature: define SCAN_DAC_LDAC_EN to add the LDAC state. ldac_n
// then pulses low for H cycles after GAP. Without the macro, ldac_n is tied
// high, the DAC updates on the cs_n rising edge, and GAP returns to IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   scan_value   current scan generator output
//   scan_enable  when high, a change of scan_value requests a write
//   update       one-cycle strobe that forces a write of scan_value
//   busy         high while a frame, its gap or its LDAC pulse is in progress
//   done         one-cycle pulse on return to IDLE
//   sent_value   value of the most recently started frame
//   sclk         SPI clock, idles low; the DAC samples mosi on its rising edge
//   mosi         SPI data, MSB first
//   cs_n         DAC chip select, active low
//   ldac_n       DAC load strobe, active low
// -----------------------------------------------------------------------------
module scan_dac_spi #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] scan_value,
    input  logic                  scan_enable,
    input  logic                  update,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] sent_value,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  ldac_n
);

    // One down-counter serves every timed phase. The longest phase is the
    // gap (CS_GAP*H), or two half-periods when CS_GAP is small.
    localparam int CNT_MAX = ((CS_GAP > 2) ? CS_GAP : 2) * CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(CS_GAP * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
`ifdef SCAN_DAC_LDAC_EN
        , ST_LDAC
`endif
    } state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;   // bits still to be clocked out
    logic                  phase_hi, phase_hi_d; // current SHIFT half: sclk high
    logic [DATA_WIDTH-1:0] shreg, shreg_d;

    logic                  sent_valid, sent_valid_d;
    logic                  pending, pending_d;
    logic [DATA_WIDTH-1:0] sent_value_d;
    logic                  busy_d, done_d, cs_n_d, sclk_d, mosi_d;
    logic                  frame_d;

    logic                  changed, req, start;

    // The first enabled value after reset always counts as a change, even 0.
    assign changed = !sent_valid || (scan_value != sent_value);
    assign req     = update || (scan_enable && changed);
    assign start   = (state == ST_IDLE) && (req || pending);

    // ------------------------------------------------------------------
    // State register: holds FSM state, datapath and the registered pins
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            phase_hi   <= 1'b0;
            shreg      <= '0;
            sent_valid <= 1'b0;
            pending    <= 1'b0;
            sent_value <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_cnt    <= bit_cnt_d;
            phase_hi   <= phase_hi_d;
            shreg      <= shreg_d;
            sent_valid <= sent_valid_d;
            pending    <= pending_d;
            sent_value <= sent_value_d;
            busy       <= busy_d;
            done       <= done_d;
            cs_n       <= cs_n_d;
            sclk       <= sclk_d;
            mosi       <= mosi_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is assigned a default first. No
        // path through the case statement can leave one unassigned, so no
        // latch is inferred.
        state_d    = state;
        cnt_d      = cnt;
        bit_cnt_d  = bit_cnt;
        phase_hi_d = phase_hi;
        shreg_d    = shreg;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETUP;
                    cnt_d      = HALF_LOAD;
                    bit_cnt_d  = BIT_LOAD;
                    phase_hi_d = 1'b0;
                    shreg_d    = scan_value;
                end
            end

            ST_SETUP: begin
                if (cnt == '0) begin
                    state_d = ST_SHIFT;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            ST_SHIFT: begin
                if (cnt == '0) begin
                    cnt_d = HALF_LOAD;
                    if (!phase_hi) begin
                        phase_hi_d = 1'b1;
                    end else begin
                        // The sclk falling edge moves mosi to the next bit.
                        phase_hi_d = 1'b0;
                        shreg_d    = shreg << 1;
                        bit_cnt_d  = bit_cnt - 1'b1;
                        if (bit_cnt == BIT_W'(1)) begin
                            state_d = ST_HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            ST_HOLD: begin
                if (cnt == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt == '0) begin
`ifdef SCAN_DAC_LDAC_EN
                    state_d = ST_LDAC;
                    cnt_d   = HALF_LOAD;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

`ifdef SCAN_DAC_LDAC_EN
            ST_LDAC: begin
                if (cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered pins and bookkeeping.
    // All of these are decoded from the next state, so each pin register
    // changes on the same edge as the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        frame_d      = (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                       (state_d == ST_HOLD);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_IDLE) && (state != ST_IDLE);
        cs_n_d       = !frame_d;
        sclk_d       = (state_d == ST_SHIFT) && phase_hi_d;
        mosi_d       = frame_d && shreg_d[DATA_WIDTH-1];
        sent_value_d = start ? scan_value : sent_value;
        sent_valid_d = sent_valid || start;
        // A request seen while busy is remembered. Further requests merge
        // into the same flag, and the flag is consumed by the next start.
        pending_d    = start ? 1'b0 : (pending || (req && (state != ST_IDLE)));
    end

`ifdef SCAN_DAC_LDAC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldac_n <= 1'b1;
        end else begin
            ldac_n <= (state_d != ST_LDAC);
        end
    end
`else
    assign ldac_n = 1'b1;
`endif

endmodule

// File: tb/tb_scan_dac_spi.sv
// -----------------------------------------------------------------------------
// tb_scan_dac_spi
//
// Self-checking bench for scan_dac_spi with DATA_WIDTH=16, CLK_DIV=2 and
// CS_GAP=2. A bus monitor decodes SPI frames from the pins. It samples on the
// falling clk edge and records, for each frame, the shifted word, the cs_n low
// time and the sclk rise count. Table vectors cover the request rules. Hand
// sequences cover request merging, done/LDAC timing and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_scan_dac_spi;

    localparam int W   = 16;
    localparam int DIV = 2;
    localparam int GAP = 2;

    // Hand-computed for CLK_DIV=2, CS_GAP=2:
    //   cs_n low = 2 * (2*16 + 2) = 68 cycles
    //   done after the cs_n rise = 4 (GAP), or 6 with a 2-cycle LDAC pulse.
    localparam int CS_LOW_CYC = 68;
`ifdef SCAN_DAC_LDAC_EN
    localparam int DONE_AFTER_RISE = 6;
`else
    localparam int DONE_AFTER_RISE = 4;
`endif

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  scan_value;
    logic          scan_enable;
    logic          update;
    logic          busy;
    logic          done;
    logic [W-1:0]  sent_value;
    logic          sclk;
    logic          mosi;
    logic          cs_n;
    logic          ldac_n;

    scan_dac_spi #(
        .DATA_WIDTH (W),
        .CLK_DIV    (DIV),
        .CS_GAP     (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_value  (scan_value),
        .scan_enable (scan_enable),
        .update      (update),
        .busy        (busy),
        .done        (done),
        .sent_value  (sent_value),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .ldac_n      (ldac_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // SPI bus monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] word;
        int           low_cyc;
        int           rises;
        int           fall_cyc;
        int           rise_cyc;
        int           done_before;  // cycle of the last done seen at cs_n fall
    } frame_t;

    frame_t       frames[$];
    int           cyc            = 0;
    int           cur_low        = 0;
    int           cur_rises      = 0;
    int           cur_fall       = 0;
    int           cur_done_ref   = 0;
    logic [W-1:0] cur_word       = '0;
    bit           in_frame       = 1'b0;
    bit           prev_cs        = 1'b1;
    bit           prev_sclk      = 1'b0;
    bit           prev_ldac      = 1'b1;
    int           done_cnt       = 0;
    int           last_done_cyc  = 0;
    int           ldac_low_total = 0;
    int           ldac_first_cyc = 0;
    int           sclk_outside   = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame  = 1'b0;
            cur_rises = 0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            prev_ldac = 1'b1;
        end else begin
            if (!cs_n) begin
                if (prev_cs) begin
                    in_frame     = 1'b1;
                    cur_low      = 0;
                    cur_rises    = 0;
                    cur_word     = '0;
                    cur_fall     = cyc;
                    cur_done_ref = last_done_cyc;
                end
                cur_low++;
                if (sclk && !prev_sclk) begin
                    cur_word = {cur_word[W-2:0], mosi};
                    cur_rises++;
                end
            end else begin
                if (sclk) sclk_outside++;
                if (!prev_cs && in_frame) begin
                    frames.push_back('{cur_word, cur_low, cur_rises, cur_fall,
                                       cyc, cur_done_ref});
                    in_frame = 1'b0;
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (!ldac_n) begin
                ldac_low_total++;
                if (prev_ldac) ldac_first_cyc = cyc;
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
            prev_ldac = ldac_n;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until busy has been low for 12 consecutive cycles (bounded).
    task automatic wait_quiet(input string name);
        int  quiet = 0;
        bit  ok    = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            if (!busy) quiet++;
            else       quiet = 0;
            if (quiet >= 12) ok = 1'b1;
        end
        if (!ok) check({name, "_quiet_timeout"}, 0, 1);
    endtask

    task automatic check_frame(input string name, input int idx, input logic [W-1:0] word);
        check({name, "_word"},  int'(frames[idx].word), int'(word));
        check({name, "_cs_low"}, frames[idx].low_cyc, CS_LOW_CYC);
        check({name, "_rises"},  frames[idx].rises, W);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] value;
        logic         enable;
        logic         strobe;
        int           frames;   // frames expected from this vector
        logic [W-1:0] sent;     // sent_value expected afterwards
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n0;
        int d0;
        bit hit;

        // First enabled value after reset is sent, even 0.
        vecs[0] = '{16'h0000, 1'b1, 1'b0, 1, 16'h0000};
        vecs[1] = '{16'hA5C3, 1'b1, 1'b0, 1, 16'hA5C3};
        // Constant value: no new frame.
        vecs[2] = '{16'hA5C3, 1'b1, 1'b0, 0, 16'hA5C3};
        // Update strobe with enable low.
        vecs[3] = '{16'h1234, 1'b0, 1'b1, 1, 16'h1234};
        // Change with enable low: nothing.
        vecs[4] = '{16'h5678, 1'b0, 1'b0, 0, 16'h1234};
        // Enable rises with a value differing from sent_value.
        vecs[5] = '{16'h5678, 1'b1, 1'b0, 1, 16'h5678};
        // Forced resend of an unchanged value.
        vecs[6] = '{16'h5678, 1'b1, 1'b1, 1, 16'h5678};
        // Update and change together: a single request.
        vecs[7] = '{16'hFFFF, 1'b1, 1'b1, 1, 16'hFFFF};
        vecs[8] = '{16'h8001, 1'b0, 1'b0, 0, 16'hFFFF};
        vecs[9] = '{16'h8001, 1'b0, 1'b1, 1, 16'h8001};

        rst_n       = 1'b0;
        scan_value  = '0;
        scan_enable = 1'b0;
        update      = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_cs_n",   int'(cs_n),       1);
        check("rst_sclk",   int'(sclk),       0);
        check("rst_mosi",   int'(mosi),       0);
        check("rst_ldac_n", int'(ldac_n),     1);
        check("rst_busy",   int'(busy),       0);
        check("rst_done",   int'(done),       0);
        check("rst_sent",   int'(sent_value), 0);

        rst_n = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 10; i++) begin
            n0 = frames.size();
            d0 = done_cnt;
            scan_value  = vecs[i].value;
            scan_enable = vecs[i].enable;
            update      = vecs[i].strobe;
            tick();
            update = 1'b0;
            wait_quiet($sformatf("vec%0d", i));
            check($sformatf("vec%0d_frames", i), frames.size() - n0, vecs[i].frames);
            check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].frames);
            check($sformatf("vec%0d_sent", i), int'(sent_value), int'(vecs[i].sent));
            if (vecs[i].frames == 1 && frames.size() == n0 + 1) begin
                check_frame($sformatf("vec%0d", i), n0, vecs[i].sent);
            end
        end

        // ---------------- merged requests during a frame ----------------
        n0 = frames.size();
        d0 = done_cnt;
        scan_value  = 16'h0001;
        scan_enable = 1'b1;
        tick();
        repeat (10) tick();
        scan_value = 16'h0002;
        repeat (10) tick();
        scan_value = 16'h0003;
        wait_quiet("merge");
        check("merge_frames", frames.size() - n0, 2);
        check("merge_done",   done_cnt - d0, 2);
        check("merge_sent",   int'(sent_value), 16'h0003);
        if (frames.size() == n0 + 2) begin
            check_frame("merge_first",  n0,     16'h0001);
            check_frame("merge_second", n0 + 1, 16'h0003);
            check("merge_restart_gap",
                  frames[n0 + 1].fall_cyc - frames[n0 + 1].done_before, 1);
            check("done_after_cs_rise",
                  last_done_cyc - frames[n0 + 1].rise_cyc, DONE_AFTER_RISE);
`ifdef SCAN_DAC_LDAC_EN
            check("ldac_after_cs_rise",
                  ldac_first_cyc - frames[n0 + 1].rise_cyc, 4);
`endif
        end

        // ---------------- reset in the middle of a frame ----------------
        scan_value = 16'hBEEF;
        tick();
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (cur_rises == 7) hit = 1'b1;
        end
        check("midrst_reach_bit7", int'(hit), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", int'(cs_n),       1);
        check("midrst_sclk", int'(sclk),       0);
        check("midrst_mosi", int'(mosi),       0);
        check("midrst_busy", int'(busy),       0);
        check("midrst_sent", int'(sent_value), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = frames.size();
        wait_quiet("midrst");
        check("midrst_frames", frames.size() - n0, 1);
        check("midrst_resent", int'(sent_value), 16'hBEEF);
        if (frames.size() == n0 + 1) begin
            check_frame("midrst", n0, 16'hBEEF);
        end

        // ---------------- whole-run properties ----------------
        check("sclk_outside_cs", sclk_outside, 0);
`ifdef SCAN_DAC_LDAC_EN
        check("ldac_low_total", ldac_low_total, 2 * frames.size());
`else
        check("ldac_low_total", ldac_low_total, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_dac_spi.md
Name: scan_dac_spi

Overview:
- Downstream consumer of the scan generator's 16-bit scan value.
- Latches each new scan value and serialises it MSB-first over a write-only SPI link to an external 16-bit voltage DAC, for example an AD5541-class part.
- Optionally pulses LDAC after each frame.
- Sits between the scan generator output and the board-level DAC pins, in the same clock domain as the generator.

Parameters:
- DATA_WIDTH, 16: bits per SPI frame; must equal the scan value width.
- CLK_DIV, 4: clk cycles per SCLK half-period; minimum 1.
- CS_GAP, 2: minimum cs_n high time between frames, in SCLK half-periods; minimum 1.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- scan_value  in  DATA_WIDTH  current scan generator output.
- scan_enable  in  1  when high, any change of scan_value triggers a DAC write.
- update  in  1  single-cycle strobe; forces a write of the current scan_value regardless of change or enable.
- busy  out  1  high while a frame, its gap or its LDAC phase is in progress.
- done  out  1  single-cycle pulse when the FSM returns to IDLE.
- sent_value  out  DATA_WIDTH  value of the most recently started frame.
- sclk  out  1  SPI clock; idles low; DAC samples mosi on the rising edge.
- mosi  out  1  SPI data.
- cs_n  out  1  DAC chip select, active low.
- ldac_n  out  1  DAC load strobe, active low.

Behaviour:
- Reset
  - Asynchronous on rst_n low.
  - All outputs go idle immediately, including mid-frame: cs_n=1, sclk=0, mosi=0, ldac_n=1, busy=0, done=0, sent_value=0.
  - Pending flag cleared. Internal sent_valid flag cleared.
- Request
  - req = update OR (scan_enable AND (NOT sent_valid OR scan_value != sent_value)).
  - This makes the first enabled value after reset always sent, even if it is 0.
- Start
  - Start occurs in IDLE when req or pending is set.
  - On the start cycle (state entry, next edge): latch sent_value <= scan_value, set sent_valid, clear pending, set busy=1 and cs_n=0, drive mosi = MSB.
  - The value sent is the one present at start, not at request time.
- Request while busy
  - Sets a one-deep pending flag; further requests merge into it.
  - On return to IDLE the pending flag starts the next frame on the very next cycle, with done still pulsing.
  - A change-detect request is re-evaluated against the new sent_value.
- FSM states and durations (H = CLK_DIV cycles)
  - IDLE.
  - SETUP: cs_n low, sclk low, H cycles.
  - SHIFT: DATA_WIDTH bits. Per bit: sclk low H cycles with mosi stable, then sclk high H cycles. mosi advances to the next bit on each sclk falling edge.
  - HOLD: sclk low, cs_n low, H cycles.
  - GAP: cs_n high, mosi=0, CS_GAP*H cycles.
  - LDAC: ldac_n low, H cycles; present only with the optional feature.
  - Then IDLE.
- Timing
  - cs_n low duration = H*(2*DATA_WIDTH+2) cycles exactly.
  - Exactly DATA_WIDTH sclk rising edges per frame, all inside cs_n low.
- done pulses for one cycle on entry to IDLE; busy falls in the same cycle.
- update and change on the same cycle count as one request.
- scan_enable falling mid-frame does not abort the frame; only rst_n aborts.
- A single down-counter sized for max(CS_GAP,2)*CLK_DIV plus a bit counter of clog2(DATA_WIDTH+1) bits. No combinational path from inputs to SPI pins; all SPI outputs are registered.

Optional Feature:
- Macro: SCAN_DAC_LDAC_EN.
- Defined: LDAC state present; ldac_n pulses low for CLK_DIV cycles after GAP, and done follows the end of the pulse.
- Undefined: LDAC state removed; ldac_n is held constantly 1 and the DAC updates on the cs_n rising edge; GAP goes directly to IDLE.

Test Plan:
- Reset, then scan_enable=1, scan_value=0x0000 (CLK_DIV=2, CS_GAP=2) -> one frame of 16 zero bits; cs_n low exactly 68 cycles; 16 sclk rises; sent_value=0; done pulses once.
- scan_value=0xA5C3 held, scan_enable=1 -> mosi sampled at sclk rises = 1010_0101_1100_0011; no second frame while the value stays constant.
- During a frame, scan_value goes 0x0001 -> 0x0002 -> 0x0003 -> exactly one follow-on frame carrying 0x0003, starting the cycle after done.
- scan_enable=0, update strobe with scan_value=0x1234 -> a frame of 0x1234 is sent; a later value change with enable low sends nothing.
- rst_n low at bit 7 of a frame -> cs_n=1, sclk=0, busy=0 asynchronously; after release with enable high, the current value is resent from a fresh SETUP.
- With SCAN_DAC_LDAC_EN: ldac_n low for 2 cycles starting 4 cycles after cs_n rises, then done. Without it: ldac_n stays 1 and done comes 4 cycles after cs_n rises.
